frame_tx: RTL and testbench

- Transmit end of the three-phase frame interface (start / valid / finish strobes carrying a 5-bit word plus two single-bit fields).
- Accepts one parallel frame from the local side, latches it, and replays it to a downstream frame collector as a timed strobe sequence.
- Sits between the control datapath and the collector's capture FSM. Pacing is programmable so the collector's staged registers settle between phases.

---
 rtl/frame_tx_pkg.sv | 30 +++
 rtl/frame_tx_gap_counter.sv | 34 +++
 rtl/frame_tx.sv | 124 ++++++++++++
 tb/tb_frame_tx.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_tx_pkg.sv
// frame_tx_pkg: state encoding, gap counter width and frame field widths
// shared by the frame transmitter and the frame collector.
// Pure declarations; no logic, no latency, no flow control.
package frame_tx_pkg;

  localparam int GAP_CNT_W = 4;
  localparam int FRAME_W   = 5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    PH_DATA = 3'd2,
    PH_B0   = 3'd3,
    PH_B1   = 3'd4,
    FIN     = 3'd5,
    WAIT    = 3'd6
  } state_t;

  // Strobe state that follows a given strobe state; IDLE after FIN means "frame complete".
  function automatic state_t next_phase(input state_t s);
    case (s)
      START:   return PH_DATA;
      PH_DATA: return PH_B0;
      PH_B0:   return PH_B1;
      PH_B1:   return FIN;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/frame_tx_gap_counter.sv
// gap_counter: loadable down-counter with a zero flag, saturating at 0.
// Latency: load/decrement visible one cycle later; zero is combinational on the count.
// Backpressure: none; dec is ignored once the count has reached 0.
module gap_counter
  import frame_tx_pkg::*;
#(
  parameter int CW = GAP_CNT_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] count;

  // Load has priority over decrement; the count never wraps below zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - ONE;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/frame_tx.sv
// frame_tx: latches one parallel frame and replays it as start / 3x valid / finish strobes.
// Latency: iniciarr one cycle after the accept edge; frame = 5 strobes + 5*GAP idle cycles, then hecho.
// Backpressure: no queueing; enviar is ignored while ocupado and during the hecho cycle.
module frame_tx
  import frame_tx_pkg::*;
#(
  parameter int GAP = 2,
  parameter int W   = FRAME_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enviar,
  input  logic [W-1:0] dato,
  input  logic         b0,
  input  logic         b1,
  output logic         ocupado,
  output logic         hecho,
  output logic         iniciarr,
  output logic         validoo,
  output logic         terminarr,
  output logic [W-1:0] dd,
  output logic         d,
  output logic         d1
);

  // The counter holds "remaining wait cycles minus one", so WAIT exits when it reads zero.
  localparam logic [GAP_CNT_W-1:0] GAP_LD = GAP_CNT_W'((GAP > 0) ? GAP - 1 : 0);

  state_t       state, state_nxt;
  state_t       ret, ret_nxt;
  logic [W-1:0] hold_dat;
  logic         hold_b0, hold_b1;
  logic         accept, done;
  logic         cnt_load, cnt_dec, cnt_zero;

  gap_counter #(.CW(GAP_CNT_W)) u_gap (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (GAP_LD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Next-state: each strobe state either chains directly (GAP=0) or parks in WAIT with a return target.
  always_comb begin
    state_nxt = state;
    ret_nxt   = ret;
    accept    = 1'b0;
    done      = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    case (state)
      IDLE: begin
        // hecho is high in the first IDLE cycle; a new request waits one more cycle.
        if (enviar && !hecho) begin
          accept    = 1'b1;
          state_nxt = START;
        end
      end
      START, PH_DATA, PH_B0, PH_B1, FIN: begin
        if (GAP == 0) begin
          state_nxt = next_phase(state);
          done      = (state == FIN);
        end else begin
          state_nxt = WAIT;
          ret_nxt   = next_phase(state);
          cnt_load  = 1'b1;
        end
      end
      WAIT: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          state_nxt = ret;
          done      = (ret == IDLE);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, holding registers and registered outputs decoded from the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ret       <= IDLE;
      hold_dat  <= '0;
      hold_b0   <= 1'b0;
      hold_b1   <= 1'b0;
      ocupado   <= 1'b0;
      hecho     <= 1'b0;
      iniciarr  <= 1'b0;
      validoo   <= 1'b0;
      terminarr <= 1'b0;
      dd        <= '0;
      d         <= 1'b0;
      d1        <= 1'b0;
    end else begin
      state     <= state_nxt;
      ret       <= ret_nxt;
      if (accept) begin
        hold_dat <= dato;
        hold_b0  <= b0;
        hold_b1  <= b1;
      end
      ocupado   <= (state_nxt != IDLE);
      hecho     <= done;
      iniciarr  <= (state_nxt == START);
      validoo   <= (state_nxt == PH_DATA) || (state_nxt == PH_B0) || (state_nxt == PH_B1);
      terminarr <= (state_nxt == FIN);
      // Buses hold from their phase until completion so the collector may sample late.
      if (done) begin
        dd <= '0;
        d  <= 1'b0;
        d1 <= 1'b0;
      end else begin
        if (state_nxt == PH_DATA) dd <= hold_dat;
        if (state_nxt == PH_B0)   d  <= hold_b0;
        if (state_nxt == PH_B1)   d1 <= hold_b1;
      end
    end
  end

endmodule

// File: tb/tb_frame_tx.sv
// tb_frame_tx: drives a GAP=0 and a GAP=2 transmitter and compares every cycle with a timing model.
// Outputs sampled 1 time unit after the rising edge; a strobe-order/collector monitor runs on the falling edge.
// All loops are cycle-bounded; the run always reaches its summary line.
module tb_frame_tx;

  logic       clk;
  logic       reset;
  logic       en    [2];
  logic [4:0] dat   [2];
  logic       f0    [2];
  logic       f1    [2];
  logic       ocu   [2];
  logic       hec   [2];
  logic       ini   [2];
  logic       val   [2];
  logic       ter   [2];
  logic [4:0] o_dd  [2];
  logic       o_d   [2];
  logic       o_d1  [2];
  logic [11:0] obs  [2];
  logic [6:0] sent  [2];
  logic [6:0] cap   [2];
  int         pidx  [2];
  int         errors = 0;
  int         checks = 0;

  // index 0: GAP=0 instance, index 1: GAP=2 instance
  frame_tx #(.GAP(0), .W(5)) dut0 (
    .clk(clk), .reset(reset), .enviar(en[0]), .dato(dat[0]), .b0(f0[0]), .b1(f1[0]),
    .ocupado(ocu[0]), .hecho(hec[0]), .iniciarr(ini[0]), .validoo(val[0]),
    .terminarr(ter[0]), .dd(o_dd[0]), .d(o_d[0]), .d1(o_d1[0])
  );

  frame_tx #(.GAP(2), .W(5)) dut2 (
    .clk(clk), .reset(reset), .enviar(en[1]), .dato(dat[1]), .b0(f0[1]), .b1(f1[1]),
    .ocupado(ocu[1]), .hecho(hec[1]), .iniciarr(ini[1]), .validoo(val[1]),
    .terminarr(ter[1]), .dd(o_dd[1]), .d(o_d[1]), .d1(o_d1[1])
  );

  assign obs[0] = {ocu[0], hec[0], ini[0], val[0], ter[0], o_dd[0], o_d[0], o_d1[0]};
  assign obs[1] = {ocu[1], hec[1], ini[1], val[1], ter[1], o_dd[1], o_d[1], o_d1[1]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs t cycles after the accept edge, from the frame timing rules.
  // Packing: {ocupado, hecho, iniciarr, validoo, terminarr, dd[4:0], d, d1}
  function automatic logic [11:0] model(input int t, input int g, input logic [4:0] w,
                                        input logic v0, input logic v1);
    int p;
    logic [11:0] r;
    p = g + 1;
    r = '0;
    if (t >= 1 && t <= 5 * p) begin
      r[11] = 1'b1;
      if ((t - 1) % p == 0) begin
        case ((t - 1) / p)
          0:       r[9] = 1'b1;
          4:       r[7] = 1'b1;
          default: r[8] = 1'b1;
        endcase
      end
      if (t >= 1 + p)     r[6:2] = w;
      if (t >= 1 + 2 * p) r[1]   = v0;
      if (t >= 1 + 3 * p) r[0]   = v1;
    end else if (t == 5 * p + 1) begin
      r[10] = 1'b1;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Protocol monitor: strobes one-hot-or-zero in order start, valid x3, finish; collector capture.
  always @(negedge clk) begin
    logic [2:0] s, e;
    for (int i = 0; i < 2; i++) begin
      s = obs[i][9:7];
      if (!reset) begin
        pidx[i] = 0;
      end else if (s != 3'b000) begin
        e = (pidx[i] == 0) ? 3'b100 : (pidx[i] == 4) ? 3'b001 : 3'b010;
        checks++;
        if (s !== e) begin
          errors++;
          $display("FAIL proto_order dut%0d step=%0d strobes=%b expected=%b", i, pidx[i], s, e);
        end
        if (pidx[i] == 1) cap[i][6:2] = obs[i][6:2];
        if (pidx[i] == 2) cap[i][1]   = obs[i][1];
        if (pidx[i] == 3) cap[i][0]   = obs[i][0];
        if (pidx[i] == 4) begin
          checks++;
          if (cap[i] !== sent[i]) begin
            errors++;
            $display("FAIL collector dut%0d captured=%b expected=%b", i, cap[i], sent[i]);
          end
        end
        pidx[i] = (pidx[i] + 1) % 5;
      end
    end
  end

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b0; dat[i] = '0; f0[i] = 1'b0; f1[i] = 1'b0; sent[i] = '0; cap[i] = '0; pidx[i] = 0;
    end
    #12;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs[i] !== 12'h000) begin
        errors++;
        $display("FAIL reset_state dut%0d got=%b exp=%b", i, obs[i], 12'h000);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [11:0] e;
    dat[1] = 5'b10110; f0[1] = 1'b1; f1[1] = 1'b0;
    sent[1] = {5'b10110, 1'b1, 1'b0};
    en[1] = 1'b1;
    for (int t = 1; t <= 18; t++) begin
      tick();
      en[1] = 1'b0;
      e = model(t, 2, 5'b10110, 1'b1, 1'b0);
      checks++;
      if (obs[1] !== e) begin
        errors++;
        $display("FAIL basic t=%0d got=%b exp=%b", t, obs[1], e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] e;
    dat[0] = 5'h1F; f0[0] = 1'b0; f1[0] = 1'b1;
    sent[0] = {5'h1F, 1'b0, 1'b1};
    en[0] = 1'b1;
    for (int t = 1; t <= 17; t++) begin
      tick();
      // second frame accepted at the edge closing cycle 7 (one cycle after hecho)
      e = (t <= 7) ? model(t, 0, 5'h1F, 1'b0, 1'b1) : model(t - 7, 0, 5'h1F, 1'b0, 1'b1);
      checks++;
      if (obs[0] !== e) begin
        errors++;
        $display("FAIL back_to_back t=%0d got=%b exp=%b", t, obs[0], e);
      end
      if (t == 14) en[0] = 1'b0;
    end
  endtask

  task automatic test_input_change();
    logic [11:0] e;
    dat[1] = 5'h03; f0[1] = 1'b0; f1[1] = 1'b1;
    sent[1] = {5'h03, 1'b0, 1'b1};
    en[1] = 1'b1;
    for (int t = 1; t <= 17; t++) begin
      tick();
      en[1] = 1'b0;
      if (t == 2) begin
        dat[1] = 5'h1C; f0[1] = 1'b1; f1[1] = 1'b0;
      end
      e = model(t, 2, 5'h03, 1'b0, 1'b1);
      checks++;
      if (obs[1] !== e) begin
        errors++;
        $display("FAIL input_change t=%0d got=%b exp=%b", t, obs[1], e);
      end
    end
  endtask

  task automatic test_ignored();
    logic [11:0] e;
    logic [4:0]  w;
    logic        v0, v1, prev;
    int          falls;
    w = 5'($urandom); v0 = 1'($urandom); v1 = 1'($urandom);
    dat[1] = w; f0[1] = v0; f1[1] = v1; sent[1] = {w, v0, v1};
    en[1] = 1'b1;
    falls = 0;
    prev = 1'b0;
    for (int t = 1; t <= 26; t++) begin
      tick();
      if (t == 1) en[1] = 1'b0;
      if (t == 7) en[1] = 1'b1;   // PH_B0 cycle
      if (t == 8) en[1] = 1'b0;
      if (prev && !ocu[1]) falls++;
      prev = ocu[1];
      e = model(t, 2, w, v0, v1);
      checks++;
      if (obs[1] !== e) begin
        errors++;
        $display("FAIL ignored t=%0d got=%b exp=%b", t, obs[1], e);
      end
    end
    checks++;
    if (falls !== 1) begin
      errors++;
      $display("FAIL ignored_falls got=%0d exp=1", falls);
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] e;
    logic [4:0]  w;
    logic        v0, v1;
    w = 5'($urandom); v0 = 1'($urandom); v1 = 1'($urandom);
    dat[1] = w; f0[1] = v0; f1[1] = v1; sent[1] = {w, v0, v1};
    en[1] = 1'b1;
    for (int t = 1; t <= 5; t++) begin
      tick();
      en[1] = 1'b0;
      e = model(t, 2, w, v0, v1);
      checks++;
      if (obs[1] !== e) begin
        errors++;
        $display("FAIL reset_mid_pre t=%0d got=%b exp=%b", t, obs[1], e);
      end
    end
    #2 reset = 1'b0;              // mid-cycle, WAIT after PH_DATA
    #1;
    checks++;
    if (obs[1] !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid_async got=%b exp=%b", obs[1], 12'h000);
    end
    tick();
    tick();
    reset = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      checks++;
      if (obs[1] !== 12'h000) begin
        errors++;
        $display("FAIL reset_mid_quiet t=%0d got=%b exp=%b", t, obs[1], 12'h000);
      end
    end
    w = 5'($urandom); v0 = 1'($urandom); v1 = 1'($urandom);
    dat[1] = w; f0[1] = v0; f1[1] = v1; sent[1] = {w, v0, v1};
    en[1] = 1'b1;
    for (int t = 1; t <= 18; t++) begin
      tick();
      en[1] = 1'b0;
      e = model(t, 2, w, v0, v1);
      checks++;
      if (obs[1] !== e) begin
        errors++;
        $display("FAIL reset_mid_after t=%0d got=%b exp=%b", t, obs[1], e);
      end
    end
  endtask

  task automatic test_random();
    logic [11:0] e;
    logic [4:0]  w;
    logic        v0, v1;
    int          g, i, idle;
    for (int n = 0; n < 8; n++) begin
      i = n % 2;
      g = (i == 0) ? 0 : 2;
      idle = $urandom_range(0, 3);
      for (int k = 0; k < idle; k++) begin
        tick();
        checks++;
        if (obs[i] !== 12'h000) begin
          errors++;
          $display("FAIL random_idle dut%0d got=%b exp=%b", i, obs[i], 12'h000);
        end
      end
      w = 5'($urandom); v0 = 1'($urandom); v1 = 1'($urandom);
      dat[i] = w; f0[i] = v0; f1[i] = v1; sent[i] = {w, v0, v1};
      en[i] = 1'b1;
      for (int t = 1; t <= 5 * (g + 1) + 2; t++) begin
        tick();
        en[i] = 1'b0;
        dat[i] = 5'($urandom);
        e = model(t, g, w, v0, v1);
        checks++;
        if (obs[i] !== e) begin
          errors++;
          $display("FAIL random dut%0d n=%0d t=%0d got=%b exp=%b", i, n, t, obs[i], e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_input_change();
    test_ignored();
    test_reset_mid();
    test_random();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
